// File: rtl/wb_pkg.sv
// Shared Wishbone responder definitions: cycle-type codes, wait counter width, FSM states.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Wait counter holds WAIT_CYCLES values 0..15
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_BURST,
        S_DRAIN
    } wb_slv_state_e;

endpackage

// File: rtl/wb_slave_mem.sv
// Single-port synchronous word RAM with per-byte write enables and a registered read port.
module wb_slave_mem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   sel_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage is never reset; only bytes with sel set are written
    always_ff @(posedge clk_i) begin
        for (int unsigned b = 0; b < NB; b++) begin
            if (we_i && sel_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_sdram_slave_model.sv
// Wishbone B3 responder with wait-stated first beat, incrementing bursts and byte-enabled memory.
// Optional WB_SLAVE_ERR_EN: out-of-range addresses terminate with wb_err_o instead of aliasing.
module wb_sdram_slave_model
    import wb_pkg::*;
#(
    parameter int unsigned data_width    = 32,
    parameter int unsigned address_width = 26,
    parameter int unsigned MEM_DEPTH     = 1024,
    parameter int unsigned WAIT_CYCLES   = 2
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       wb_cyc_i,
    input  logic                       wb_stb_i,
    input  logic                       wb_we_i,
    input  logic [address_width-1:0]   wb_addr_i,
    input  logic [data_width-1:0]      wb_dat_i,
    input  logic [data_width/8-1:0]    wb_sel_i,
    input  logic [2:0]                 wb_cti_i,
    output logic                       wb_ack_o,
`ifdef WB_SLAVE_ERR_EN
    output logic                       wb_err_o,
`endif
    output logic [data_width-1:0]      wb_dat_o
);

    localparam int unsigned SEL_W    = data_width / 8;
    localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
    localparam int unsigned WORD_LSB = $clog2(SEL_W);
    localparam int unsigned HI_LSB   = WORD_LSB + IDX_W;

    wb_slv_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  addr_q, addr_d;
    logic              ack_q, ack_d;
    logic              req_c;
    logic              last_beat_c;
    logic              mem_we_c;
    logic              mem_re_c;

`ifdef WB_SLAVE_ERR_EN
    logic              err_q, err_d;
    logic              hi_q, hi_d;
    logic              addr_hi_nz_c;

    // Any set bit above the word index makes the access out of range
    assign addr_hi_nz_c = |(wb_addr_i >> HI_LSB);
`else
    logic              unused_addr_c;

    assign unused_addr_c = ^wb_addr_i;
`endif

    assign req_c       = wb_cyc_i & wb_stb_i;
    assign last_beat_c = (wb_cti_i == CTI_EOB) || (wb_cti_i == CTI_CLASSIC);

    // Next-state, address/counter update and memory strobes
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        ack_d    = 1'b0;
        mem_we_c = 1'b0;
        mem_re_c = 1'b0;
`ifdef WB_SLAVE_ERR_EN
        err_d    = 1'b0;
        hi_d     = hi_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_c) begin
                    addr_d = wb_addr_i[WORD_LSB +: IDX_W];
                    cnt_d  = CNT_W'(WAIT_CYCLES);
`ifdef WB_SLAVE_ERR_EN
                    hi_d   = addr_hi_nz_c;
`endif
                    state_d = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
                end
            end

            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_ACK;
                end
            end

            S_ACK: begin
                state_d = S_DRAIN;
                if (req_c) begin
`ifdef WB_SLAVE_ERR_EN
                    if (hi_q) begin
                        err_d = 1'b1;
                    end else begin
`endif
                        ack_d    = 1'b1;
                        mem_we_c = wb_we_i;
                        mem_re_c = ~wb_we_i;
                        addr_d   = addr_q + IDX_W'(1);
                        if (wb_cti_i == CTI_INCR) begin
                            state_d = S_BURST;
                        end
`ifdef WB_SLAVE_ERR_EN
                    end
`endif
                end
            end

            // While ack is high the bus still shows the beat being acked; a last beat ends the burst
            S_BURST: begin
                if (req_c) begin
                    if (ack_q && last_beat_c) begin
                        state_d = S_DRAIN;
                    end else begin
                        ack_d    = 1'b1;
                        mem_we_c = wb_we_i;
                        mem_re_c = ~wb_we_i;
                        addr_d   = addr_q + IDX_W'(1);
                    end
                end
            end

            S_DRAIN: begin
                if (!wb_stb_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!wb_cyc_i) begin
            state_d  = S_IDLE;
            ack_d    = 1'b0;
            mem_we_c = 1'b0;
            mem_re_c = 1'b0;
`ifdef WB_SLAVE_ERR_EN
            err_d    = 1'b0;
`endif
        end

        // A reset edge never commits a write
        if (wb_rst_i) begin
            mem_we_c = 1'b0;
            mem_re_c = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            ack_q   <= 1'b0;
`ifdef WB_SLAVE_ERR_EN
            err_q   <= 1'b0;
            hi_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ack_q   <= ack_d;
`ifdef WB_SLAVE_ERR_EN
            err_q   <= err_d;
            hi_q    <= hi_d;
`endif
        end
    end

    wb_slave_mem #(
        .DATA_W (data_width),
        .DEPTH  (MEM_DEPTH),
        .ADDR_W (IDX_W)
    ) u_mem (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .we_i    (mem_we_c),
        .re_i    (mem_re_c),
        .addr_i  (addr_q),
        .wdata_i (wb_dat_i),
        .sel_i   (wb_sel_i),
        .rdata_o (wb_dat_o)
    );

    assign wb_ack_o = ack_q;
`ifdef WB_SLAVE_ERR_EN
    assign wb_err_o = err_q;
`endif

endmodule
